param_updown_counter: RTL
=========================

Name: param_updown_counter

Overview:
- Parametrised successor to the team's fixed 4-bit free-running counter.
- Generalised in width and modulus; adds count direction, count enable, synchronous parallel load, and a selectable wrap or saturate mode.
- Reports terminal count, overflow/underflow event pulses, and a sticky error flag.
- Used as a shared timing and event counter inside control datapaths. It is also the formal/assertion target for the counter verification suite.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MAX_VAL, 15, highest count value (modulus - 1); must satisfy 1 <= MAX_VAL <= 2**WIDTH - 1; elaboration error otherwise.
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- en, input, 1, count enable.
- up_dn, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, synchronous parallel load strobe.
- load_val, input, WIDTH, value applied on load.
- clear_flags, input, 1, clears sticky_err.
- counter, output, WIDTH, current count (registered).
- overflow, output, 1, registered one-cycle pulse: an increment was attempted at MAX_VAL.
- underflow, output, 1, registered one-cycle pulse: a decrement was attempted at 0.
- tc_max, output, 1, combinational: counter == MAX_VAL.
- tc_min, output, 1, combinational: counter == 0.
- sticky_err, output, 1, registered; set by any overflow or underflow event, held until cleared.

Behaviour:
- Reset: while reset is high at a clock edge, counter=0, overflow=0, underflow=0, sticky_err=0. tc_min=1 and tc_max=0 follow from counter=0. Reset overrides every other input, including mid-load and mid-count.
- Priority at each edge: reset > load > en. up_dn is ignored unless en=1 and load=0.
- Load: counter <= min(load_val, MAX_VAL).
  - load_val above MAX_VAL clamps to MAX_VAL.
  - No overflow/underflow pulse on a load.
  - A load in the same cycle as en=1 performs the load only.
- Hold: when en=0 and load=0, counter holds, and overflow=0 and underflow=0 on the next cycle.
- Increment (en=1, up_dn=1):
  - If counter < MAX_VAL: counter+1, overflow=0.
  - If counter == MAX_VAL and SATURATE=0: counter <= 0 and overflow=1.
  - If counter == MAX_VAL and SATURATE=1: counter holds at MAX_VAL and overflow=1.
- Decrement (en=1, up_dn=0):
  - If counter > 0: counter-1, underflow=0.
  - If counter == 0 and SATURATE=0: counter <= MAX_VAL and underflow=1.
  - If counter == 0 and SATURATE=1: counter holds at 0 and underflow=1.
- Pulse timing: overflow/underflow go high in the cycle where counter shows the post-event value, for exactly one cycle per event. In saturate mode, repeated attempts at the boundary give one pulse per cycle. overflow and underflow are never high together.
- sticky_err:
  - Next value = (sticky_err & ~clear_flags) | event, where event is the overflow/underflow condition detected this edge.
  - If an event and clear_flags occur in the same cycle, set wins.
  - clear_flags has no effect on counter.
- Arithmetic: the counter never holds a value above MAX_VAL. Internal +1/-1 is computed at WIDTH+1 bits so there is no accidental native wrap when MAX_VAL = 2**WIDTH - 1.
- tc_max/tc_min are purely combinational from counter; with MAX_VAL >= 1 both are never high at the same time.
- Required assertions, disabled during reset:
  - counter <= MAX_VAL.
  - One-step change when en=1 and load=0.
  - Pulses mutually exclusive.
  - sticky_err never falls without clear_flags.

Test Plan:
- WIDTH=4, MAX_VAL=15, SATURATE=0: reset, then en=1, up_dn=1 for 17 cycles -> counter 1..15, then 0 with overflow=1 for one cycle, then 1 with overflow=0; sticky_err=1 from the wrap cycle onward.
- WIDTH=4, MAX_VAL=9, SATURATE=0: from 0, en=1, up_dn=0 -> counter=9, underflow=1; then 8, underflow=0; tc_max=1 only while counter=9.
- WIDTH=4, MAX_VAL=9, SATURATE=1: load 9, then 3 increments -> counter stays 9 with overflow=1 each cycle; then clear_flags=1 alongside a further increment -> sticky_err stays 1; then clear_flags=1 with en=0 -> sticky_err=0.
- Load clamp/priority: load=1, load_val=13, en=1, MAX_VAL=9 -> counter=9, no pulse; load=1, load_val=4 -> counter=4.
- Reset mid-operation: count to 7, assert reset together with load=1 and en=1 -> next cycle counter=0, overflow=0, underflow=0, sticky_err=0.
- Hold: en=0 for 5 cycles at counter=6 with up_dn toggling -> counter stays 6 and no pulses.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with enable, synchronous load, wrap or
// saturate boundary handling, terminal-count flags, overflow/underflow
// event pulses and a sticky error flag.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 15,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] counter,
  output logic             overflow,
  output logic             underflow,
  output logic             tc_max,
  output logic             tc_min,
  output logic             sticky_err
);

  // Reject illegal parameter combinations at elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("param_updown_counter: WIDTH must be in 1..32");
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH:0]   MAXW = {1'b0, MAXV};
  localparam logic [WIDTH:0]   ONEW = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic [WIDTH-1:0] cnt_d;
  logic             ovf_d;
  logic             unf_d;

  // Next count and boundary events; +1/-1 carried at WIDTH+1 bits so the
  // carry/borrow bit detects the boundary even when MAX_VAL is all ones.
  always_comb begin
    inc   = {1'b0, counter} + ONEW;
    dec   = {1'b0, counter} - ONEW;
    cnt_d = counter;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (inc > MAXW) begin
          ovf_d = 1'b1;
          cnt_d = SATURATE ? MAXV : '0;
        end else begin
          cnt_d = inc[WIDTH-1:0];
        end
      end else begin
        if (dec[WIDTH]) begin
          unf_d = 1'b1;
          cnt_d = SATURATE ? '0 : MAXV;
        end else begin
          cnt_d = dec[WIDTH-1:0];
        end
      end
    end
  end

  // Count register, event pulses and sticky error; set wins over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      counter    <= cnt_d;
      overflow   <= ovf_d;
      underflow  <= unf_d;
      sticky_err <= (sticky_err & ~clear_flags) | ovf_d | unf_d;
    end
  end

  assign tc_max = (counter == MAXV);
  assign tc_min = (counter == '0);

  a_in_range : assert property (@(posedge clk) disable iff (reset)
    counter <= MAXV);

  a_one_step : assert property (@(posedge clk) disable iff (reset)
    (en && !load) |=>
      (({1'b0, counter} == {1'b0, $past(counter)} + ONEW) ||
       ({1'b0, counter} + ONEW == {1'b0, $past(counter)}) ||
       (($past(counter) == MAXV) && (counter == '0 || counter == MAXV)) ||
       (($past(counter) == '0) && (counter == MAXV || counter == '0))));

  a_pulse_excl : assert property (@(posedge clk) disable iff (reset)
    !(overflow && underflow));

  a_sticky_hold : assert property (@(posedge clk) disable iff (reset)
    (!$past(reset) && $fell(sticky_err)) |-> $past(clear_flags));

endmodule
